// File: rtl/ac97_frame_tx.sv
// AC'97 output-frame serialiser: 256-bit frames (tag, cmd addr/data, NUM_CH PCM slots, pad) on SYNC/SDATA_OUT.
// Latency: frame bit 0 on the pins 2 cycles after reset release; back-to-back 256-cycle frames after that.
// Backpressure: cmd and PCM are sampled once per frame (last bit); ack/ready pulse only in that cycle.
module ac97_frame_tx #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 20
) (
  input  logic                         bit_clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*SAMPLE_W-1:0]   i_pcm_data,
  input  logic                         i_pcm_valid,
  output logic                         o_pcm_ready,
  input  logic                         i_cmd_req,
  input  logic                         i_cmd_rd,
  input  logic [6:0]                   i_cmd_addr,
  input  logic [15:0]                  i_cmd_data,
  output logic                         o_cmd_ack,
  output logic                         o_sync,
  output logic                         o_sdata_out,
  output logic                         o_frame_start,
  output logic                         o_underflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_TAG, S_CMD_ADDR, S_CMD_DATA, S_PCM, S_PAD
  } state_t;

  localparam int PCM_END = 56 + 20 * NUM_CH;

  state_t                       r_state;
  state_t                       w_nxt_state;
  logic [7:0]                   r_cnt;
  logic [7:0]                   w_nxt_cnt;
  logic                         w_cap;
  logic                         w_sync_nxt;

  logic                         r_cmd_vld;
  logic                         r_cmd_rd;
  logic [6:0]                   r_cmd_addr;
  logic [15:0]                  r_cmd_data;
  logic                         r_pcm_vld;
  logic [NUM_CH*SAMPLE_W-1:0]   r_pcm;

  logic                         r_sync;
  logic                         r_sdata;
  logic                         r_fs;

  logic [9:0]                   w_pcm_tags;
  logic [199:0]                 w_pcm_region;
  logic [255:0]                 w_frame;

  // Slot owning a given frame bit; the counter is the only timing source.
  function automatic state_t slot_of(input logic [7:0] c);
    if (c < 8'd16)                  return S_TAG;
    else if (c < 8'd36)             return S_CMD_ADDR;
    else if (c < 8'd56)             return S_CMD_DATA;
    else if ({1'b0, c} < 9'(PCM_END)) return S_PCM;
    else                            return S_PAD;
  endfunction

  // Per-channel tag bit and left-justified 20-bit slot; unused channels stay zero.
  for (genvar k = 0; k < 10; k++) begin : g_slot
    if (k < NUM_CH) begin : g_used
      assign w_pcm_tags[9-k] = r_pcm_vld;
      assign w_pcm_region[199-20*k -: 20] =
        20'(r_pcm[k*SAMPLE_W +: SAMPLE_W]) << (20 - SAMPLE_W);
    end else begin : g_unused
      assign w_pcm_tags[9-k] = 1'b0;
      assign w_pcm_region[199-20*k -: 20] = 20'h00000;
    end
  end

  // Whole frame image, frame bit 0 at [255]; latched regs are already zeroed when absent.
  assign w_frame = {1'b1, r_cmd_vld, r_cmd_vld & ~r_cmd_rd, w_pcm_tags, 3'b000,
                    r_cmd_rd, r_cmd_addr, 12'h000,
                    r_cmd_data, 4'h0,
                    w_pcm_region};

  // State and bit counter register.
  always_ff @(posedge bit_clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Next state/counter, capture strobe (IDLE or last bit), and next SYNC level.
  always_comb begin
    w_nxt_cnt   = r_cnt + 8'd1;
    w_cap       = 1'b0;
    w_sync_nxt  = 1'b0;
    if (r_state == S_IDLE) begin
      w_nxt_cnt = 8'd0;
      w_cap     = 1'b1;
    end else begin
      w_cap = (r_cnt == 8'hFF);
    end
    w_nxt_state = slot_of(w_nxt_cnt);
    w_sync_nxt  = (r_state == S_TAG);
  end

  // Latch command and samples for the coming frame; absent items are cleared so slots read zero.
  always_ff @(posedge bit_clk) begin
    if (!rst_n) begin
      r_cmd_vld  <= 1'b0;
      r_cmd_rd   <= 1'b0;
      r_cmd_addr <= 7'd0;
      r_cmd_data <= 16'd0;
      r_pcm_vld  <= 1'b0;
      r_pcm      <= '0;
    end else if (w_cap) begin
      r_cmd_vld  <= i_cmd_req;
      r_cmd_rd   <= i_cmd_req & i_cmd_rd;
      r_cmd_addr <= i_cmd_req ? i_cmd_addr : 7'd0;
      r_cmd_data <= (i_cmd_req && !i_cmd_rd) ? i_cmd_data : 16'd0;
      r_pcm_vld  <= i_pcm_valid;
      r_pcm      <= i_pcm_valid ? i_pcm_data : '0;
    end
  end

  // Registered pins: SYNC and data stay aligned one cycle behind the counter.
  always_ff @(posedge bit_clk) begin
    if (!rst_n) begin
      r_sync  <= 1'b0;
      r_sdata <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_sync  <= w_sync_nxt;
      r_sdata <= (r_state != S_IDLE) && w_frame[~r_cnt];
      r_fs    <= (r_state == S_TAG) && (r_cnt == 8'd0);
    end
  end

  assign o_sync        = r_sync;
  assign o_sdata_out   = r_sdata;
  assign o_frame_start = r_fs;
  // Handshake strobes are combinational so valid&ready marks the exact capture edge.
  assign o_cmd_ack     = rst_n & w_cap & i_cmd_req;
  assign o_pcm_ready   = rst_n & w_cap & i_pcm_valid;
  assign o_underflow   = rst_n & w_cap & ~i_pcm_valid;

endmodule
